// File: rtl/mem_read_seq.sv
// Burst read sequencer: issues sequential wrapping reads to a registered-output memory
// and streams the returned words through a 2-entry skid buffer. Optional: MEM_READ_SEQ_CHECKSUM_EN.
module mem_read_seq #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              rden,
  output logic [ADDR_W-1:0] addr_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef MEM_READ_SEQ_CHECKSUM_EN
  , output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [ADDR_W:0]   MAXLEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] AINC   = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t                   state, nstate;
  logic [ADDR_W:0]          len_eff, rd_left, out_left;
  logic                     accept, inflight, pop, pop_buf, push;
  logic [1:0]               cnt;
  logic                     wp, rp;
  logic [1:0][DATA_W-1:0]   sbuf;
  logic [2:0]               occ;

  assign len_eff = (length > MAXLEN) ? MAXLEN : length;
  assign accept  = (state == IDLE) && start && (length != '0);

  // An empty buffer passes the returning word straight through, which gives the
  // 2-cycle start latency; a word not taken that cycle lands in the buffer.
  assign out_valid = (cnt != 2'd0) || inflight;
  assign pop       = out_valid && out_ready;
  assign pop_buf   = pop && (cnt != 2'd0);
  assign push      = inflight && !(pop && (cnt == 2'd0));
  assign out_last  = out_valid && (out_left == ONE);

  always_comb begin
    out_data = '0;
    if (cnt != 2'd0)   out_data = sbuf[rp];
    else if (inflight) out_data = mem_data;
  end

  // Occupancy after this cycle's transfer; keeps buffered + in-flight within 2.
  assign occ = {1'b0, cnt} + {2'b0, inflight} - {2'b0, pop};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    rden   = 1'b0;
    busy   = (state != IDLE);
    case (state)
      IDLE:  if (accept) nstate = READ;
      READ: begin
        rden = (occ < 3'd2);
        if (rden && rd_left == ONE) nstate = DRAIN;
      end
      DRAIN: if (pop && out_left == ONE) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_rd  <= '0;
      rd_left  <= '0;
      out_left <= '0;
      inflight <= 1'b0;
      cnt      <= '0;
      wp       <= 1'b0;
      rp       <= 1'b0;
      sbuf     <= '0;
      done     <= 1'b0;
    end else begin
      inflight <= rden;
      done     <= (state == DRAIN) && pop && (out_left == ONE);
      if (accept) begin
        addr_rd  <= base_addr;
        rd_left  <= len_eff;
        out_left <= len_eff;
      end else begin
        if (rden) begin
          addr_rd <= addr_rd + AINC;
          rd_left <= rd_left - ONE;
        end
        if (pop) out_left <= out_left - ONE;
      end
      if (push) begin
        sbuf[wp] <= mem_data;
        wp       <= ~wp;
      end
      if (pop_buf) rp <= ~rp;
      cnt <= cnt + {1'b0, push} - {1'b0, pop_buf};
    end
  end

`ifdef MEM_READ_SEQ_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || accept) checksum <= '0;
    else if (pop)      checksum <= checksum ^ out_data;
  end
`endif

endmodule

// File: tb/tb_mem_read_seq.sv
// Scoreboard bench for mem_read_seq: directed bursts push expected addresses/words,
// a negedge monitor pops and compares whenever the DUT issues a read or transfers a word.
module tb_mem_read_seq;
  localparam int DW = 24;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          rden;
  logic [AW-1:0] addr_rd;
  logic [DW-1:0] mem_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;
`ifdef MEM_READ_SEQ_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  mem_read_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .rden(rden), .addr_rd(addr_rd), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
`ifdef MEM_READ_SEQ_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [32];
  always @(posedge clk) if (rden) mem_data <= mem[addr_rd];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  logic [DW:0]   dq[$];
  logic [AW-1:0] aq[$];
  int  pops, first_cyc, last_pop_cyc, done_cnt, outstd;
  bit  busy_seen, rden_seen, prev_hold, rmode;
  logic [DW-1:0] prev_data;
  int  rcnt = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ready pattern 1,0,0,1 repeating when rmode is set
  initial forever begin
    @(posedge clk); #1;
    out_ready = rmode ? ((rcnt % 4 == 0) || (rcnt % 4 == 3)) : 1'b1;
    rcnt++;
  end

  always @(negedge clk) begin
    if (rst) begin
      outstd = 0;
      prev_hold = 0;
    end else begin
      if (busy) begin busy_seen = 1; chk("outstanding_le2", outstd <= 2, 1); end
      if (rden) begin
        rden_seen = 1;
        if (aq.size() == 0) chk("unexpected_rden", 1, 0);
        else chk("addr_rd", 32'(addr_rd), 32'(aq.pop_front()));
      end
      if (prev_hold) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (dq.size() == 0) chk("unexpected_word", 1, 0);
        else begin
          logic [DW:0] e;
          e = dq.pop_front();
          chk("out_data", 32'(out_data), 32'(e[DW-1:0]));
          chk("out_last", 32'(out_last), 32'(e[DW]));
        end
        if (pops == 0) first_cyc = cyc;
        last_pop_cyc = cyc;
        pops++;
      end
      if (done) done_cnt++;
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      outstd = outstd + int'(rden) - int'(out_valid && out_ready);
    end
  end

  task automatic expect_burst(input logic [AW-1:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      a = b + AW'(i);
      aq.push_back(a);
      dq.push_back({(i == n - 1), 24'h100 + 24'(a)});
    end
  endtask

  task automatic issue(input logic [AW-1:0] b, input logic [AW:0] l);
    @(posedge clk); #1;
    start = 1; base_addr = b; length = l;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic run_burst(input logic [AW-1:0] b, input logic [AW:0] l, input int n,
                           input bit timing, input bit dup, input logic [31:0] ck);
    int start_cyc;
    bit got;
    pops = 0; done_cnt = 0; first_cyc = -1;
    @(posedge clk); #1;
    start = 1; base_addr = b; length = l;
    @(negedge clk) start_cyc = cyc;
    @(posedge clk); #1;
    start = 0;
    if (dup) begin
      @(posedge clk); #1; start = 1; base_addr = 5'd17; length = 6'd5;
      @(posedge clk); #1; start = 0;
    end
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
`ifdef MEM_READ_SEQ_CHECKSUM_EN
        if (ck != 32'hFFFF_FFFF) chk("checksum", 32'(checksum), ck);
`endif
      end
    end
    chk("done_seen", 32'(got), 1);
    chk("done_idle", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("done_count", done_cnt, 1);
    chk("word_count", pops, n);
    chk("dq_empty", dq.size(), 0);
    chk("aq_empty", aq.size(), 0);
    if (timing) begin
      chk("first_latency", first_cyc - start_cyc, 2);
      chk("back_to_back", last_pop_cyc - first_cyc, n - 1);
    end
  endtask

  initial begin
    bit got;
    rmode = 0;
    for (int i = 0; i < 32; i++) mem[i] = 24'h100 + 24'(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rden", 32'(rden), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_addr", 32'(addr_rd), 0);
    chk("rst_data", 32'(out_data), 0);
    @(posedge clk); #1 rst = 0;

    expect_burst(5'd0, 4);
    run_burst(5'd0, 6'd4, 4, 1, 1, 32'hFFFF_FFFF);

    expect_burst(5'd30, 4);
    run_burst(5'd30, 6'd4, 4, 1, 0, 32'hFFFF_FFFF);

    expect_burst(5'd5, 8);
    rcnt = 0; rmode = 1;
    run_burst(5'd5, 6'd8, 8, 0, 0, 32'hFFFF_FFFF);
    rmode = 0;

    busy_seen = 0; rden_seen = 0; done_cnt = 0;
    issue(5'd3, 6'd0);
    repeat (10) @(negedge clk);
    chk("len0_busy", 32'(busy_seen), 0);
    chk("len0_rden", 32'(rden_seen), 0);
    chk("len0_done", done_cnt, 0);

    expect_burst(5'd0, 32);
    run_burst(5'd0, 6'd40, 32, 1, 0, 32'hFFFF_FFFF);

    expect_burst(5'd0, 10);
    pops = 0; done_cnt = 0;
    issue(5'd0, 6'd10);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (pops == 2) got = 1;
    end
    chk("rst_test_reach", 32'(got), 1);
    @(posedge clk); #1;
    rst = 1;
    dq.delete(); aq.delete();
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("abort_rden", 32'(rden), 0);
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_last", 32'(out_last), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_addr", 32'(addr_rd), 0);
    chk("abort_data", 32'(out_data), 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);

    expect_burst(5'd2, 3);
    run_burst(5'd2, 6'd3, 3, 1, 0, 32'hFFFF_FFFF);

    mem[0] = 24'h000001; mem[1] = 24'h000002; mem[2] = 24'h000004;
    aq.push_back(5'd0); aq.push_back(5'd1); aq.push_back(5'd2);
    dq.push_back({1'b0, 24'h000001});
    dq.push_back({1'b0, 24'h000002});
    dq.push_back({1'b1, 24'h000004});
    run_burst(5'd0, 6'd3, 3, 1, 0, 32'h0000_0007);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/mem_read_seq.md
MEM_READ_SEQ -- requirements
Module: mem_read_seq

Interface
REQ-001 Parameter DATA_W, default 24, SHALL set the data word width.
REQ-002 Parameter ADDR_W, default 5, SHALL set the address width; depth is 2**ADDR_W (32).
REQ-003 clk, input, 1: the single clock; the memory read clock SHALL be tied to clk.
REQ-004 rst, input, 1: reset, synchronous and active-high.
REQ-005 start, input, 1: one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 base_addr, input, ADDR_W: first address of the burst; captured on accepted start.
REQ-007 length, input, ADDR_W+1: burst word count; captured on accepted start.
REQ-008 rden, output, 1: memory read enable.
REQ-009 addr_rd, output, ADDR_W: memory read address.
REQ-010 mem_data, input, DATA_W: memory read data, registered by the memory, valid one cycle after rden.
REQ-011 out_valid / out_ready, output / input, 1 each: downstream stream handshake.
REQ-012 out_data, output, DATA_W: stream word.
REQ-013 out_last, output, 1: asserted with the final word of a burst.
REQ-014 busy, output, 1: high in every state other than IDLE.
REQ-015 done, output, 1: one-cycle pulse on the cycle after the last word transfers.

Function
REQ-016 States SHALL be IDLE, READ and DRAIN.
REQ-017 IDLE->READ SHALL occur on start=1 with length!=0; start with length=0 SHALL be ignored, with no done pulse.
REQ-018 Length values greater than 32 SHALL be treated as 32.
REQ-019 addr_rd SHALL begin at base_addr and increment by 1 per issued read, wrapping from 31 to 0.
REQ-020 A word transfers when out_valid&&out_ready.
REQ-021 A 2-entry output skid buffer SHALL hold returned data; rden SHALL assert only when (buffered + in-flight) < 2.
REQ-022 With out_ready held high, rden SHALL be high on every READ cycle and throughput SHALL be 1 word/cycle.
REQ-023 Start-to-first-out_valid latency SHALL be 2 cycles.
REQ-024 READ->DRAIN SHALL occur when the last read issues; DRAIN->IDLE SHALL occur when the last word transfers.
REQ-025 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 Words SHALL be emitted in address order with none dropped or duplicated.
REQ-027 done SHALL pulse on the cycle IDLE is re-entered.
REQ-028 start while busy SHALL be ignored.

Reset
REQ-029 On rst=1 at a clk edge, the block SHALL enter IDLE, and rden, out_valid, out_last, busy, done, addr_rd, out_data and the skid buffer SHALL be cleared to 0.
REQ-030 rst mid-burst SHALL abort the burst; a read return in flight SHALL be discarded and no done pulse SHALL be produced.

Configuration
REQ-031 With MEM_READ_SEQ_CHECKSUM_EN defined, output checksum[DATA_W-1:0] SHALL be the XOR of all words transferred in the current burst, cleared on accepted start and on rst, and valid while done=1.
REQ-032 Without MEM_READ_SEQ_CHECKSUM_EN, the checksum port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Memory preloaded with mem[i]=i+0x100; start with base=0, len=4, ready=1 -> outputs 0x100..0x103 on consecutive cycles, first 2 cycles after start, out_last on 0x103, done on the next cycle.
REQ-034 base=30, len=4 -> addresses 30, 31, 0, 1 and data 0x11E, 0x11F, 0x100, 0x101.
REQ-035 len=8, ready toggled 1,0,0,1,... -> all 8 words in order, out_data stable during stalls, rden never leaves more than 2 words outstanding.
REQ-036 len=0 with start -> busy stays 0, no rden, no done; len=40 -> exactly 32 words.
REQ-037 rst asserted on the 3rd word of a len=10 burst -> next cycle IDLE with all outputs 0; a new start then runs correctly.
REQ-038 With the macro defined, len=3 data 0x000001, 0x000002, 0x000004 -> checksum=0x000007 while done=1.
